gemm_sequencer: RTL and testbench

GEMM_SEQUENCER -- requirements
Module: gemm_sequencer

---
 rtl/datapath_pkg.sv | 27 ++
 rtl/gemm_sequencer_if.sv | 37 +++
 rtl/gemm_sequencer.sv | 120 ++++++++++++
 tb/tb_gemm_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types for the GEMM sequencer: matrix ids, op descriptor and
// sequencer state encoding.
package datapath_pkg;

    localparam int unsigned MAT_DIM  = 4;
    localparam int unsigned ROW_W    = $clog2(MAT_DIM);
    localparam int unsigned MAT_BITS = 4;
    // Writeback counter has to hold MAT_DIM itself (saturation value).
    localparam int unsigned WB_CNT_W = $clog2(MAT_DIM + 1);

    typedef logic [MAT_BITS-1:0] matbits_t;

    typedef struct packed {
        matbits_t rd;
        matbits_t rs3;
        matbits_t rs2;
        matbits_t rs1;
    } fu_gemm_t;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_LOAD_W = 2'd1,
        SEQ_LOAD_X = 2'd2,
        SEQ_DRAIN  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gemm_sequencer_if.sv
// Bundle of op handshake, matrix-register-file read, systolic-array and
// writeback signals around the GEMM sequencer.
interface gemm_sequencer_if;
    import datapath_pkg::*;

    logic                 gemm_valid;
    logic                 new_weight;
    fu_gemm_t             gemm_matrix_num;
    logic                 gemm_ready;
    logic                 sa_ready;
    logic                 sa_out_valid;
    logic                 mrf_ren_a;
    matbits_t             mrf_sel_a;
    logic                 mrf_ren_b;
    matbits_t             mrf_sel_b;
    logic [ROW_W-1:0]     mrf_row;
    logic                 sa_wload;
    logic                 sa_xload;
    logic                 wb_en;
    matbits_t             wb_sel;
    logic [ROW_W-1:0]     wb_row;
    logic                 done;

    // Sequencer side: receives ops and array status, drives reads and writeback.
    modport slave (
        input  gemm_valid, new_weight, gemm_matrix_num, sa_ready, sa_out_valid,
        output gemm_ready, mrf_ren_a, mrf_sel_a, mrf_ren_b, mrf_sel_b, mrf_row,
               sa_wload, sa_xload, wb_en, wb_sel, wb_row, done
    );

    modport master (
        output gemm_valid, new_weight, gemm_matrix_num, sa_ready, sa_out_valid,
        input  gemm_ready, mrf_ren_a, mrf_sel_a, mrf_ren_b, mrf_sel_b, mrf_row,
               sa_wload, sa_xload, wb_en, wb_sel, wb_row, done
    );

endinterface

// File: rtl/gemm_sequencer.sv
// Sequences one GEMM op: optional weight load, input/psum streaming, and
// collection of MAT_DIM result rows into the destination matrix.
module gemm_sequencer
    import datapath_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    gemm_sequencer_if.slave   bus
);

    seq_state_t             state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [WB_CNT_W-1:0]    wb_cnt_q, wb_cnt_d;
    fu_gemm_t               op_q, op_d;
    logic                   done_q, done_d;
    logic                   wb_take;
    logic                   row_last;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= SEQ_IDLE;
            row_q    <= '0;
            wb_cnt_q <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            wb_cnt_q <= wb_cnt_d;
            op_q     <= op_d;
            done_q   <= done_d;
        end
    end

    assign row_last = (row_q == ROW_W'(MAT_DIM - 1));

    // Next-state and output decode; outputs are pure functions of state and array status.
    always_comb begin
        state_d            = state_q;
        row_d              = row_q;
        wb_cnt_d           = wb_cnt_q;
        op_d               = op_q;
        done_d             = 1'b0;
        wb_take            = 1'b0;
        bus.gemm_ready     = 1'b0;
        bus.mrf_ren_a      = 1'b0;
        bus.mrf_sel_a      = '0;
        bus.mrf_ren_b      = 1'b0;
        bus.mrf_sel_b      = '0;
        bus.mrf_row        = '0;
        bus.sa_wload       = 1'b0;
        bus.sa_xload       = 1'b0;
        bus.wb_en          = 1'b0;
        bus.wb_sel         = '0;
        bus.wb_row         = '0;
        bus.done           = done_q;

        // Results are only meaningful once inputs stream; extras past MAT_DIM are dropped.
        if ((state_q == SEQ_LOAD_X || state_q == SEQ_DRAIN) && bus.sa_out_valid
            && (wb_cnt_q < WB_CNT_W'(MAT_DIM))) begin
            wb_take    = 1'b1;
            bus.wb_en  = 1'b1;
            bus.wb_sel = op_q.rd;
            bus.wb_row = wb_cnt_q[ROW_W-1:0];
            wb_cnt_d   = wb_cnt_q + WB_CNT_W'(1);
        end

        case (state_q)
            SEQ_IDLE: begin
                bus.gemm_ready = 1'b1;
                if (bus.gemm_valid) begin
                    op_d     = bus.gemm_matrix_num;
                    row_d    = '0;
                    wb_cnt_d = '0;
                    state_d  = bus.new_weight ? SEQ_LOAD_W : SEQ_LOAD_X;
                end
            end
            SEQ_LOAD_W: begin
                bus.mrf_ren_a = 1'b1;
                bus.sa_wload  = 1'b1;
                bus.mrf_sel_a = op_q.rs2;
                bus.mrf_row   = row_q;
                if (bus.sa_ready) begin
                    if (row_last) begin
                        row_d   = '0;
                        state_d = SEQ_LOAD_X;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            SEQ_LOAD_X: begin
                bus.mrf_ren_a = 1'b1;
                bus.mrf_ren_b = 1'b1;
                bus.sa_xload  = 1'b1;
                bus.mrf_sel_a = op_q.rs1;
                bus.mrf_sel_b = op_q.rs3;
                bus.mrf_row   = row_q;
                if (bus.sa_ready) begin
                    if (row_last) begin
                        row_d   = '0;
                        state_d = SEQ_DRAIN;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            SEQ_DRAIN: begin
                // Covers both the last result arriving now and all results already in.
                if ((wb_take && wb_cnt_q == WB_CNT_W'(MAT_DIM - 1))
                    || (wb_cnt_q == WB_CNT_W'(MAT_DIM))) begin
                    state_d = SEQ_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gemm_sequencer.sv
// Self-checking bench for gemm_sequencer: directed and randomized ops against a
// row-read-stream / result-count reference model.
module tb_gemm_sequencer;
    import datapath_pkg::*;

    typedef struct {
        bit               w;
        matbits_t         a;
        matbits_t         b;
        logic [ROW_W-1:0] row;
    } rd_ev_t;

    logic CLK;
    logic nRST;
    gemm_sequencer_if bus();

    gemm_sequencer u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int       n_checks = 0;
    int       n_fail   = 0;

    // Reference model: pending row reads of the op, results written so far.
    bit       m_busy   = 1'b0;
    bit       m_done   = 1'b0;
    int       m_writes = 0;
    matbits_t m_rd     = '0;
    rd_ev_t   m_stream[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input string tag);
        logic [13:0] e_rd, o_rd;
        logic [6:0]  e_wb, o_wb;
        logic [1:0]  e_ct, o_ct;
        bit          wb_ok;
        bit          fin;
        rd_ev_t      h;
        #1;
        e_rd = '0;
        if (m_busy && m_stream.size() > 0) begin
            h    = m_stream[0];
            e_rd = {1'b1, !h.w, h.w, !h.w, h.a, h.b, h.row};
        end
        wb_ok = m_busy && (m_stream.size() == 0 || !m_stream[0].w)
                && (m_writes < int'(MAT_DIM)) && bus.sa_out_valid;
        e_wb = wb_ok ? {1'b1, m_rd, ROW_W'(m_writes)} : 7'd0;
        e_ct = {!m_busy, m_done};
        o_rd = {bus.mrf_ren_a, bus.mrf_ren_b, bus.sa_wload, bus.sa_xload,
                bus.mrf_sel_a, bus.mrf_sel_b, bus.mrf_row};
        o_wb = {bus.wb_en, bus.wb_sel, bus.wb_row};
        o_ct = {bus.gemm_ready, bus.done};
        check({tag, " read"},  32'(o_rd), 32'(e_rd));
        check({tag, " wb"},    32'(o_wb), 32'(e_wb));
        check({tag, " ctrl"},  32'(o_ct), 32'(e_ct));
        @(posedge CLK);
        if (!nRST) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_writes = 0;
            m_stream.delete();
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (bus.gemm_valid) begin
                m_busy   = 1'b1;
                m_writes = 0;
                m_rd     = bus.gemm_matrix_num.rd;
                m_stream.delete();
                if (bus.new_weight)
                    for (int r = 0; r < int'(MAT_DIM); r++)
                        m_stream.push_back('{w: 1'b1, a: bus.gemm_matrix_num.rs2,
                                             b: '0, row: ROW_W'(r)});
                for (int r = 0; r < int'(MAT_DIM); r++)
                    m_stream.push_back('{w: 1'b0, a: bus.gemm_matrix_num.rs1,
                                         b: bus.gemm_matrix_num.rs3, row: ROW_W'(r)});
            end
        end else begin
            // Op ends in a cycle with no rows left whose writes reach MAT_DIM.
            fin = (m_stream.size() == 0) && (m_writes + int'(wb_ok) == int'(MAT_DIM));
            if (wb_ok) m_writes++;
            if (m_stream.size() > 0 && bus.sa_ready) void'(m_stream.pop_front());
            if (fin) m_busy = 1'b0;
            m_done = fin;
        end
        @(negedge CLK);
    endtask

    task automatic run_op(input string tag, input bit nw, input fu_gemm_t op,
                          input int ready_pct, input int valid_pct, input int valid_from,
                          input int stall_lo, input int stall_hi, input bit hold,
                          input int abort_at, input int exp_lat);
        bit accepted = 1'b0;
        bit finished = 1'b0;
        bit was_idle;
        int k = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (accepted && m_done) begin
                finished = 1'b1;
                if (exp_lat >= 0) check({tag, " latency"}, 32'(k), 32'(exp_lat));
                break;
            end
            bus.gemm_valid      = !accepted || hold;
            bus.gemm_matrix_num = op;
            bus.new_weight      = nw;
            bus.sa_ready        = (accepted && k >= stall_lo && k < stall_hi) ? 1'b0
                                  : ($urandom_range(99) < 32'(ready_pct));
            bus.sa_out_valid    = (k >= valid_from) && ($urandom_range(99) < 32'(valid_pct));
            if (abort_at > 0 && accepted && k == abort_at) nRST = 1'b0;
            was_idle = !m_busy;
            tick(tag);
            if (!nRST) begin
                nRST     = 1'b1;
                finished = 1'b1;
                break;
            end
            if (!accepted && was_idle) begin
                accepted = 1'b1;
                k        = 1;
            end else begin
                k++;
            end
        end
        check({tag, " completes"}, 32'(finished), 32'd1);
    endtask

    fu_gemm_t op;

    initial begin
        nRST                = 1'b0;
        bus.gemm_valid      = 1'b0;
        bus.new_weight      = 1'b0;
        bus.gemm_matrix_num = '0;
        bus.sa_ready        = 1'b0;
        bus.sa_out_valid    = 1'b0;
        @(negedge CLK);

        // Reset held with inputs active: outputs idle.
        bus.gemm_valid   = 1'b1;
        bus.sa_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick("reset");
        bus.gemm_valid   = 1'b0;
        bus.sa_out_valid = 1'b0;
        nRST = 1'b1;
        tick("post_reset");

        op = '{rd: 4'd9, rs3: 4'd7, rs2: 4'd5, rs1: 4'd3};
        run_op("nw1_drain", 1'b1, op, 100, 100, 9, 0, 0, 1'b0, 0, 13);
        run_op("nw0_drain", 1'b0, op, 100, 100, 5, 0, 0, 1'b0, 0, 9);
        run_op("nw1_early", 1'b1, op, 100, 100, 0, 0, 0, 1'b0, 0, 10);
        run_op("nw1_stall", 1'b1, op, 100, 100, 12, 2, 5, 1'b0, 0, 16);

        // Reset while LOAD_X presents row 2.
        op = '{rd: 4'd1, rs3: 4'd2, rs2: 4'd6, rs1: 4'd4};
        run_op("abort", 1'b0, op, 100, 0, 0, 0, 0, 1'b0, 3, -1);
        bus.gemm_valid   = 1'b0;
        bus.sa_out_valid = 1'b1;
        tick("after_abort");
        check("abort ready", 32'(bus.gemm_ready), 32'd1);
        check("abort done",  32'(bus.done), 32'd0);

        // Held gemm_valid, back-to-back acceptance in the done cycle.
        op = '{rd: 4'd12, rs3: 4'd11, rs2: 4'd10, rs1: 4'd8};
        run_op("hold_a", 1'b1, op, 80, 60, 0, 0, 0, 1'b1, 0, -1);
        op = '{rd: 4'd15, rs3: 4'd14, rs2: 4'd13, rs1: 4'd0};
        run_op("hold_b", 1'b0, op, 80, 60, 0, 0, 0, 1'b1, 0, -1);

        for (int n = 0; n < 12; n++) begin
            op = fu_gemm_t'($urandom);
            run_op("random", 1'($urandom), op, 70, 50, 0, 0, 0, 1'($urandom), 0, -1);
        end

        // Stray results in IDLE must not write back.
        bus.gemm_valid   = 1'b0;
        bus.sa_out_valid = 1'b1;
        bus.sa_ready     = 1'b1;
        for (int i = 0; i < 3; i++) tick("idle_results");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
